rv32i_mem_arbiter: RTL and testbench
====================================

# rv32i_mem_arbiter

Single-port memory arbiter for the RV32IM pipeline. It shares one unified instruction/data memory port between the fetch stage (IF) and the memory-access stage (DM). Each transaction runs through a small FSM with a request/acknowledge handshake on every side. Data accesses have priority, and an optional starvation guard bounds how long fetch can be locked out.

## Interface
- WIDTH, 32, address/data width
- STARVE_MAX, 4, consecutive DM grants allowed while IF is pending before IF is forced (guard only)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- i_if_req  in  1  fetch request, held until o_if_ack
- i_if_addr  in  WIDTH  fetch address
- o_if_rdata  out  WIDTH  fetched instruction, valid while o_if_ack=1
- o_if_ack  out  1  one-cycle completion pulse to IF
- i_dm_req  in  1  data request, held until o_dm_ack
- i_dm_we  in  1  1=store, 0=load
- i_dm_be  in  4  byte enables
- i_dm_addr  in  WIDTH  data address
- i_dm_wdata  in  WIDTH  store data
- o_dm_rdata  out  WIDTH  load data, valid while o_dm_ack=1
- o_dm_ack  out  1  one-cycle completion pulse to DM
- o_mem_req  out  1  memory request, held until i_mem_ack
- o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata  out  1/4/WIDTH/WIDTH  latched request fields
- i_mem_rdata  in  WIDTH  memory read data, sampled with i_mem_ack
- i_mem_ack  in  1  memory completion, one cycle

## Operation
- FSM states: IDLE, ISSUE, DONE. Owner register: IF or DM.
- IDLE:
  - If any request is present, grant one of them. Latch the owner and the request fields into o_mem_*, then go to ISSUE.
  - IF grants set o_mem_we=0 and o_mem_be=4'hF.
  - Grant priority: DM wins over IF, except when the starvation override applies (see Configuration).
- ISSUE: o_mem_req=1 and o_mem_* are held stable. When i_mem_ack=1, register i_mem_rdata into the owner's rdata and go to DONE.
- DONE: the owner's ack is 1 for exactly this cycle. Go to IDLE.
- Requesters must not change their request fields while req is high and ack has not been seen. A requester deasserts req, or presents a new request, at the edge that ends its ack cycle.
- rdata holds its last value between transactions. A store acks with rdata unchanged.
- The non-owner's ack is always 0. At most one ack is high per cycle.

## Timing
- Reset values: all outputs are 0. State=IDLE, owner=DM, starvation counter=0.
- Asserting reset mid-transaction drops o_mem_req asynchronously and abandons the transaction; no ack is issued. The memory side must tolerate the aborted request.
- Minimum latency: request in IDLE at cycle 0, o_mem_req at cycle 1, i_mem_ack at cycle 1, owner ack at cycle 2. That is 3 cycles request-to-ack, plus one extra cycle per memory wait cycle.
- Back-to-back throughput is one transaction per 3 cycles. Cycle 3 is IDLE, where the next grant is taken.
- Simultaneous IF and DM requests in IDLE: DM is granted, subject to the guard below.
- i_mem_ack outside ISSUE is ignored.

## Configuration
- Macro `MEM_ARB_STARVE_GUARD_EN`.
- Defined:
  - A 3-bit-minimum saturating counter increments on each DM grant taken while i_if_req=1.
  - The counter clears on any IF grant.
  - When counter==STARVE_MAX and i_if_req=1 in IDLE, IF is granted even if i_dm_req=1.
- Undefined: no counter is built and strict DM priority applies; IF can starve indefinitely.

## Test plan
- Lone fetch, no wait states:
  - Stimulus: i_if_req=1, i_if_addr=0x10; memory acks in the first ISSUE cycle with rdata 0x00500093.
  - Response: o_mem_addr=0x10, o_mem_we=0, o_mem_be=4'hF; o_if_ack at cycle 2 with o_if_rdata=0x00500093.
- Store with 2 wait cycles:
  - Stimulus: DM we=1, be=4'b0011, addr=0x104, wdata=0xDEADBEEF.
  - Response: o_mem_* fields match and are stable for 3 ISSUE cycles; o_dm_ack at cycle 4; o_if_ack stays 0.
- Simultaneous requests, guard undefined:
  - Stimulus: IF and DM requests asserted at the same time, DM reissuing immediately after each ack for 10 transactions.
  - Response: all 10 grants go to DM and o_if_ack never pulses.
- Same stimulus, guard defined, STARVE_MAX=4:
  - Response: grant order is DM,DM,DM,DM,IF,DM,DM,DM,DM,IF.
- Reset during ISSUE:
  - Stimulus: rst low in cycle 1 with the memory stalled.
  - Response: o_mem_req=0 combinationally, no ack; after release, the first held request restarts from IDLE.
- Ack discipline:
  - Stimulus: random wait states over 200 mixed transactions.
  - Response: no cycle has both acks high; ack is never high outside DONE; o_mem_* never change while o_mem_req=1.

Source files
------------

// File: rtl/rv32i_mem_arbiter.sv
// Shares one memory port between fetch (IF) and data (DM). A transaction goes IDLE -> ISSUE -> DONE, so it takes 3 cycles plus memory wait cycles. DM has priority over IF.
// Each requester holds its request until it sees its ack. Define MEM_ARB_STARVE_GUARD_EN to cap how many DM grants in a row can lock out a pending IF.
module rv32i_mem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_if_req,
    input  logic [WIDTH-1:0] i_if_addr,
    output logic [WIDTH-1:0] o_if_rdata,
    output logic             o_if_ack,
    input  logic             i_dm_req,
    input  logic             i_dm_we,
    input  logic [3:0]       i_dm_be,
    input  logic [WIDTH-1:0] i_dm_addr,
    input  logic [WIDTH-1:0] i_dm_wdata,
    output logic [WIDTH-1:0] o_dm_rdata,
    output logic             o_dm_ack,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [3:0]       o_mem_be,
    output logic [WIDTH-1:0] o_mem_addr,
    output logic [WIDTH-1:0] o_mem_wdata,
    input  logic [WIDTH-1:0] i_mem_rdata,
    input  logic             i_mem_ack
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t           state_q, state_d;
    logic             owner_if_q, owner_if_d;
    logic             mem_we_q, mem_we_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic             force_if, grant_if, grant_dm;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    logic [CW-1:0] starve_q, starve_d;

    assign force_if = i_if_req && (starve_q == CW'(STARVE_MAX));

    // Counts DM wins over a waiting IF, saturating at the threshold.
    always_comb begin
        starve_d = starve_q;
        if (grant_if)
            starve_d = '0;
        else if (grant_dm && i_if_req && (starve_q != CW'(STARVE_MAX)))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) starve_q <= '0;
        else      starve_q <= starve_d;
    end
`else
    logic [31:0] unused_starve_max;
    assign unused_starve_max = 32'(STARVE_MAX);
    assign force_if          = 1'b0;
`endif

    assign grant_dm = (state_q == IDLE) && i_dm_req && !force_if;
    assign grant_if = (state_q == IDLE) && i_if_req && !grant_dm;

    always_comb begin
        state_d     = state_q;
        owner_if_d  = owner_if_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d     = ISSUE;
                    owner_if_d  = 1'b0;
                    mem_we_d    = i_dm_we;
                    mem_be_d    = i_dm_be;
                    mem_addr_d  = i_dm_addr;
                    mem_wdata_d = i_dm_wdata;
                end else if (grant_if) begin
                    state_d    = ISSUE;
                    owner_if_d = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_be_d   = 4'hF;
                    mem_addr_d = i_if_addr;
                end
            end
            ISSUE: begin
                if (i_mem_ack) begin
                    state_d = DONE;
                    // Stores leave the owner's read data untouched.
                    if (!mem_we_q) begin
                        if (owner_if_q) if_rdata_d = i_mem_rdata;
                        else            dm_rdata_d = i_mem_rdata;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_if_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_if_q  <= owner_if_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    // Request is decoded from state, so an async reset drops it immediately.
    assign o_mem_req   = (state_q == ISSUE);
    assign o_if_ack    = (state_q == DONE) &&  owner_if_q;
    assign o_dm_ack    = (state_q == DONE) && !owner_if_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_be    = mem_be_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed and randomized bench for rv32i_mem_arbiter; a negedge memory responder supplies acks.
// IF addresses have bit 31 clear and DM addresses have bit 31 set, so the owner can be told from o_mem_addr.
module tb_rv32i_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_addr = '0;
    logic [31:0] o_if_rdata;
    logic        o_if_ack;
    logic        i_dm_req = 1'b0;
    logic        i_dm_we = 1'b0;
    logic [3:0]  i_dm_be = '0;
    logic [31:0] i_dm_addr = '0;
    logic [31:0] i_dm_wdata = '0;
    logic [31:0] o_dm_rdata;
    logic        o_dm_ack;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata = '0;
    logic        i_mem_ack = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    bit          rnd_mode = 1'b0;
    int          mem_wait = 0;
    int          wcnt = 0;
    logic [31:0] mem_rdata_val = '0;

    rv32i_mem_arbiter #(.WIDTH(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata), .o_if_ack(o_if_ack),
        .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_be(i_dm_be), .i_dm_addr(i_dm_addr),
        .i_dm_wdata(i_dm_wdata), .o_dm_rdata(o_dm_rdata), .o_dm_ack(o_dm_ack),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack)
    );

    always #5 clk = ~clk;

    // Directed mode acks after mem_wait stall cycles; random mode pulses ack at random, including outside ISSUE.
    always @(negedge clk) begin
        if (rnd_mode) begin
            i_mem_ack   = ($urandom_range(0, 2) == 0);
            i_mem_rdata = $urandom;
        end else begin
            i_mem_ack = 1'b0;
            if (o_mem_req) begin
                if (wcnt == mem_wait) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = mem_rdata_val;
                    wcnt        = 0;
                end else begin
                    wcnt = wcnt + 1;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({o_mem_req, o_if_ack, o_dm_ack, o_mem_we} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got req/ifack/dmack/we=%b want 0000", {o_mem_req, o_if_ack, o_dm_ack, o_mem_we});
        end
        n_checks++;
        if ({o_mem_be, o_mem_addr, o_mem_wdata} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_fields: got be=%h addr=%h wdata=%h want 0", o_mem_be, o_mem_addr, o_mem_wdata);
        end
        n_checks++;
        if ({o_if_rdata, o_dm_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got if=%h dm=%h want 0", o_if_rdata, o_dm_rdata);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_lone_fetch();
        mem_wait      = 0;
        mem_rdata_val = 32'h0050_0093;
        i_if_addr     = 32'h10;
        i_if_req      = 1'b1;
        tick();
        n_checks++;
        if ({o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_if_ack} !== {1'b1, 1'b0, 4'hF, 32'h10, 1'b0}) begin
            n_fail++;
            $display("FAIL fetch_issue: got req=%b we=%b be=%h addr=%h ack=%b want 1 0 f 00000010 0",
                     o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_if_ack);
        end
        tick();
        n_checks++;
        if ({o_if_ack, o_dm_ack, o_if_rdata} !== {2'b10, 32'h0050_0093}) begin
            n_fail++;
            $display("FAIL fetch_ack: got ifack=%b dmack=%b rdata=%h want 1 0 00500093", o_if_ack, o_dm_ack, o_if_rdata);
        end
        i_if_req = 1'b0;
        tick();
        n_checks++;
        if ({o_if_ack, o_mem_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL fetch_after: got ifack=%b req=%b want 0 0", o_if_ack, o_mem_req);
        end
    endtask

    task automatic test_dm_load();
        mem_wait      = 0;
        mem_rdata_val = 32'hCAFE_F00D;
        i_dm_we       = 1'b0;
        i_dm_be       = 4'hF;
        i_dm_addr     = 32'h200;
        i_dm_wdata    = 32'h0;
        i_dm_req      = 1'b1;
        tick();
        n_checks++;
        if ({o_mem_req, o_mem_we, o_mem_addr} !== {1'b1, 1'b0, 32'h200}) begin
            n_fail++;
            $display("FAIL load_issue: got req=%b we=%b addr=%h want 1 0 00000200", o_mem_req, o_mem_we, o_mem_addr);
        end
        tick();
        n_checks++;
        if ({o_dm_ack, o_if_ack, o_dm_rdata, o_if_rdata} !== {2'b10, 32'hCAFE_F00D, 32'h0050_0093}) begin
            n_fail++;
            $display("FAIL load_ack: got dmack=%b ifack=%b dm=%h if=%h want 1 0 cafef00d 00500093",
                     o_dm_ack, o_if_ack, o_dm_rdata, o_if_rdata);
        end
        i_dm_req = 1'b0;
        tick();
    endtask

    task automatic test_store_wait();
        mem_wait      = 2;
        mem_rdata_val = 32'h1234_5678;
        i_dm_we       = 1'b1;
        i_dm_be       = 4'b0011;
        i_dm_addr     = 32'h104;
        i_dm_wdata    = 32'hDEAD_BEEF;
        i_dm_req      = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_checks++;
            if ({o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata, o_dm_ack, o_if_ack} !==
                {1'b1, 1'b1, 4'b0011, 32'h104, 32'hDEAD_BEEF, 2'b00}) begin
                n_fail++;
                $display("FAIL store_issue_c%0d: got req=%b we=%b be=%b addr=%h wdata=%h dmack=%b ifack=%b", c,
                         o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata, o_dm_ack, o_if_ack);
            end
        end
        tick();
        n_checks++;
        if ({o_dm_ack, o_if_ack, o_dm_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL store_ack: got dmack=%b ifack=%b rdata=%h want 1 0 cafef00d", o_dm_ack, o_if_ack, o_dm_rdata);
        end
        i_dm_req = 1'b0;
        i_dm_we  = 1'b0;
        mem_wait = 0;
        tick();
    endtask

    task automatic test_starvation();
        bit order[10];
        int nack = 0;
        mem_wait      = 0;
        mem_rdata_val = 32'h0000_0013;
        i_if_addr     = 32'h40;
        i_dm_we       = 1'b0;
        i_dm_be       = 4'hF;
        i_dm_addr     = 32'h300;
        i_if_req      = 1'b1;
        i_dm_req      = 1'b1;
        for (int c = 0; c < 60 && nack < 10; c++) begin
            tick();
            if (o_dm_ack) begin order[nack] = 1'b0; nack++; end
            else if (o_if_ack) begin order[nack] = 1'b1; nack++; end
        end
        i_if_req = 1'b0;
        i_dm_req = 1'b0;
        n_checks++;
        if (nack != 10) begin
            n_fail++;
            $display("FAIL starve_timeout: got %0d acks want 10", nack);
        end
        for (int k = 0; k < nack; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            bit exp_if = (k == 4) || (k == 9);
`else
            bit exp_if = 1'b0;
`endif
            n_checks++;
            if (order[k] !== exp_if) begin
                n_fail++;
                $display("FAIL starve_grant%0d: got %s want %s", k, order[k] ? "IF" : "DM", exp_if ? "IF" : "DM");
            end
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        mem_wait      = 1000;
        mem_rdata_val = 32'h0BAD_C0DE;
        i_dm_we       = 1'b0;
        i_dm_be       = 4'hF;
        i_dm_addr     = 32'h500;
        i_dm_req      = 1'b1;
        tick();
        n_checks++;
        if (o_mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_issue: got req=%b want 1", o_mem_req);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (o_mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got req=%b want 0", o_mem_req);
        end
        tick();
        tick();
        n_checks++;
        if ({o_dm_ack, o_if_ack, o_dm_rdata} !== 34'h0) begin
            n_fail++;
            $display("FAIL rstmid_noack: got dmack=%b ifack=%b rdata=%h want 0 0 0", o_dm_ack, o_if_ack, o_dm_rdata);
        end
        mem_wait = 0;
        rst      = 1'b1;
        tick();
        n_checks++;
        if ({o_mem_req, o_mem_addr, o_dm_ack} !== {1'b1, 32'h500, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_restart: got req=%b addr=%h dmack=%b want 1 00000500 0", o_mem_req, o_mem_addr, o_dm_ack);
        end
        tick();
        n_checks++;
        if ({o_dm_ack, o_dm_rdata} !== {1'b1, 32'h0BAD_C0DE}) begin
            n_fail++;
            $display("FAIL rstmid_ack: got dmack=%b rdata=%h want 1 0badc0de", o_dm_ack, o_dm_rdata);
        end
        i_dm_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bit          if_act = 1'b0, dm_act = 1'b0;
        bit          p_req = 1'b0, p_we = 1'b0, exp_if, exp_dm;
        logic [3:0]  p_be = '0;
        logic [31:0] p_addr = '0, p_wdata = '0;
        logic [31:0] if_rd_m = 32'h0;
        logic [31:0] dm_rd_m = 32'h0BAD_C0DE;
        int          ntx = 0;
        rnd_mode = 1'b1;
        for (int c = 0; c < 6000 && ntx < 200; c++) begin
            tick();
            exp_if = p_req && i_mem_ack && !p_addr[31];
            exp_dm = p_req && i_mem_ack &&  p_addr[31];
            n_checks++;
            if ({o_if_ack, o_dm_ack} !== {exp_if, exp_dm}) begin
                n_fail++;
                $display("FAIL rnd_ack c%0d: got if/dm=%b%b want %b%b", c, o_if_ack, o_dm_ack, exp_if, exp_dm);
            end
            if (exp_if) if_rd_m = i_mem_rdata;
            if (exp_dm && !p_we) dm_rd_m = i_mem_rdata;
            n_checks++;
            if ({o_if_rdata, o_dm_rdata} !== {if_rd_m, dm_rd_m}) begin
                n_fail++;
                $display("FAIL rnd_rdata c%0d: got if=%h dm=%h want %h %h", c, o_if_rdata, o_dm_rdata, if_rd_m, dm_rd_m);
            end
            if (p_req) begin
                n_checks++;
                if (i_mem_ack ? (o_mem_req !== 1'b0) :
                    ({o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata} !== {1'b1, p_we, p_be, p_addr, p_wdata})) begin
                    n_fail++;
                    $display("FAIL rnd_hold c%0d: got req=%b we=%b be=%h addr=%h wdata=%h", c,
                             o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata);
                end
            end else if (o_mem_req) begin
                n_checks++;
                if (o_mem_addr[31] ? !(dm_act && {o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata} ==
                                                  {i_dm_we, i_dm_be, i_dm_addr, i_dm_wdata})
                                   : !(if_act && {o_mem_we, o_mem_be, o_mem_addr} == {1'b0, 4'hF, i_if_addr})) begin
                    n_fail++;
                    $display("FAIL rnd_grant c%0d: got we=%b be=%h addr=%h wdata=%h", c,
                             o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata);
                end
            end
            if (exp_if) begin if_act = 1'b0; ntx++; end
            if (exp_dm) begin dm_act = 1'b0; ntx++; end
            if (!if_act && $urandom_range(0, 1) == 1) begin
                if_act    = 1'b1;
                i_if_addr = {16'h0, 14'($urandom), 2'b00};
            end
            if (!dm_act && $urandom_range(0, 1) == 1) begin
                dm_act     = 1'b1;
                i_dm_we    = 1'($urandom);
                i_dm_be    = 4'($urandom);
                i_dm_addr  = {16'h8000, 14'($urandom), 2'b00};
                i_dm_wdata = $urandom;
            end
            i_if_req = if_act;
            i_dm_req = dm_act;
            p_req    = o_mem_req;
            p_we     = o_mem_we;
            p_be     = o_mem_be;
            p_addr   = o_mem_addr;
            p_wdata  = o_mem_wdata;
        end
        n_checks++;
        if (ntx < 200) begin
            n_fail++;
            $display("FAIL rnd_timeout: got %0d transactions want 200", ntx);
        end
        i_if_req = 1'b0;
        i_dm_req = 1'b0;
        rnd_mode = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lone_fetch();
        test_dm_load();
        test_store_wait();
        test_starvation();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
